// File: rtl/blake_pkg.sv
// blake_pkg
//   Shared definitions for the BLAKE nonce scanner and the blake core.
//   Contents:
//     NONCE_W / HDR_W / HASH_W : default datapath widths
//     WORD_W                   : word size used by the target comparator
//     BLAKE_PAD                : message padding appended by blake to an 80-byte header
//     scan_state_t             : scanner FSM states
//     satInc                   : saturating increment for the hash counter
package blake_pkg;

  localparam int NONCE_W = 32;
  localparam int HDR_W   = 640;
  localparam int HASH_W  = 512;
  localparam int CNT_W   = 32;
  localparam int WORD_W  = 64;

  // A 640-bit header fills a 1024-bit BLAKE-512 block up to 384 bits of padding:
  // 0x80 marker, zero fill, 0x01 terminator byte, then the 128-bit message bit length.
  localparam int                 PAD_W     = 384;
  localparam logic [PAD_W-1:0]   BLAKE_PAD = {8'h80, 240'h0, 8'h01, 128'd640};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_REPORT,
    S_DRAIN
  } scan_state_t;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/blake_target_cmp.sv
// blake_target_cmp
//   Unsigned W-bit "a <= b" comparator assembled from 64-bit word compares.
//   Ports:
//     clk, rstb : clock and synchronous active-low reset (used only by the output register)
//     i_a, i_b  : operands, bit W-1 is the MSB
//     o_le      : 1 when i_a <= i_b; registered (one cycle later) when REG_OUT=1
module blake_target_cmp
  import blake_pkg::*;
#(
  parameter int W       = HASH_W,
  parameter bit REG_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_le
);

  localparam int NWORDS = W / WORD_W;

  logic w_le;
  logic r_le;

  // Walk from the least significant word upward so that the most significant
  // differing word has the final say; all-equal leaves the result at 1.
  always_comb begin
    w_le = 1'b1;
    for (int i = 0; i < NWORDS; i++) begin
      if (i_a[i*WORD_W +: WORD_W] < i_b[i*WORD_W +: WORD_W]) begin
        w_le = 1'b1;
      end else if (i_a[i*WORD_W +: WORD_W] > i_b[i*WORD_W +: WORD_W]) begin
        w_le = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_le <= 1'b0;
    end else begin
      r_le <= w_le;
    end
  end

  assign o_le = REG_OUT ? r_le : w_le;

endmodule

// File: rtl/blake_nonce_scan.sv
// blake_nonce_scan
//   Job sequencer wrapped around one blake core. Takes a header template, an
//   inclusive (wrapping) nonce range and a 512-bit target, hashes one nonce at a
//   time and reports every nonce whose hash is <= target.
//   Ports:
//     clk, rstb                 : clock, synchronous active-low reset
//     job_valid/job_ready       : job handshake (sampled only in IDLE)
//     job_header/_nonce_start/_nonce_end/_target : job contents
//     abort                     : cancel current job
//     core_ena/core_din         : start pulse and registered input to blake
//     core_dout/core_rdy        : hash result and its one-cycle valid pulse
//     found_valid/found_ready   : hit handshake, found_nonce/found_hash payload
//     done                      : one-cycle pulse when the range is exhausted
//     busy                      : not IDLE
//     hash_count                : saturating count of hashes for the current job
module blake_nonce_scan
  import blake_pkg::*;
#(
  parameter int NONCE_W     = blake_pkg::NONCE_W,
  parameter int HDR_W       = blake_pkg::HDR_W,
  parameter int HASH_W      = blake_pkg::HASH_W,
  parameter bit CMP_REG_OUT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [HDR_W-NONCE_W-1:0] job_header,
  input  logic [NONCE_W-1:0]       job_nonce_start,
  input  logic [NONCE_W-1:0]       job_nonce_end,
  input  logic [HASH_W-1:0]        job_target,
  input  logic                     abort,
  output logic                     core_ena,
  output logic [HDR_W-1:0]         core_din,
  input  logic [HASH_W-1:0]        core_dout,
  input  logic                     core_rdy,
  output logic                     found_valid,
  input  logic                     found_ready,
  output logic [NONCE_W-1:0]       found_nonce,
  output logic [HASH_W-1:0]        found_hash,
  output logic                     done,
  output logic                     busy,
  output logic [31:0]              hash_count
);

  scan_state_t r_state;
  scan_state_t w_next;

  logic [HDR_W-NONCE_W-1:0] r_header;
  logic [NONCE_W-1:0]       r_nonce;
  logic [NONCE_W-1:0]       r_end;
  logic [HASH_W-1:0]        r_target;
  logic [HASH_W-1:0]        r_hash;
  logic [31:0]              r_hashCount;
  logic                     r_done;
  logic                     r_cmpPend;

  logic w_le;
  logic w_cmpValid;
  logic w_atEnd;
  logic w_step;

  blake_target_cmp #(
    .W       (HASH_W),
    .REG_OUT (CMP_REG_OUT)
  ) u_cmp (
    .clk  (clk),
    .rstb (rstb),
    .i_a  (r_hash),
    .i_b  (r_target),
    .o_le (w_le)
  );

  // With a registered comparator the verdict lags hash_q by a cycle, so the
  // first CHECK cycle after a capture is spent waiting for it.
  assign w_cmpValid = !(CMP_REG_OUT && r_cmpPend);
  assign w_atEnd    = (r_nonce == r_end);

  // A nonce is finished either by a miss in CHECK or by the host taking a hit;
  // abort pre-empts both.
  assign w_step = !abort &&
                  (((r_state == S_CHECK) && w_cmpValid && !w_le) ||
                   ((r_state == S_REPORT) && found_ready));

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // An abort landing together with core_rdy in WAIT has nothing left to drain,
  // so it returns straight to IDLE instead of waiting for a pulse that never comes.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (job_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_next = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort)         w_next = core_rdy ? S_IDLE : S_DRAIN;
        else if (core_rdy) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_cmpValid) begin
          if (w_le)         w_next = S_REPORT;
          else if (w_atEnd) w_next = S_IDLE;
          else              w_next = S_ISSUE;
        end
      end
      S_REPORT: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (found_ready) begin
          w_next = w_atEnd ? S_IDLE : S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (core_rdy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    job_ready   = (r_state == S_IDLE);
    busy        = (r_state != S_IDLE);
    core_ena    = (r_state == S_ISSUE);
    found_valid = (r_state == S_REPORT);
  end

  // done is registered so it appears in the cycle the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_header    <= '0;
      r_nonce     <= '0;
      r_end       <= '0;
      r_target    <= '0;
      r_hash      <= '0;
      r_hashCount <= '0;
      r_done      <= 1'b0;
      r_cmpPend   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == S_IDLE) && job_valid) begin
        r_header    <= job_header;
        r_nonce     <= job_nonce_start;
        r_end       <= job_nonce_end;
        r_target    <= job_target;
        r_hashCount <= '0;
      end
      if ((r_state == S_WAIT) && core_rdy && !abort) begin
        r_hash      <= core_dout;
        r_hashCount <= satInc(r_hashCount);
        r_cmpPend   <= 1'b1;
      end
      if (r_state == S_CHECK) begin
        r_cmpPend <= 1'b0;
      end
      if (w_step) begin
        if (w_atEnd) r_done  <= 1'b1;
        else         r_nonce <= r_nonce + 1'b1;
      end
    end
  end

  assign core_din    = {r_header, r_nonce};
  assign found_nonce = r_nonce;
  assign found_hash  = r_hash;
  assign hash_count  = r_hashCount;
  assign done        = r_done;

endmodule

// File: tb/tb_blake_nonce_scan.sv
// tb_blake_nonce_scan
//   Self-checking bench for blake_nonce_scan with a behavioural blake core,
//   a table of directed jobs, randomized jobs against a range/threshold model,
//   and hand sequences for back-pressure, abort-in-WAIT and reset-in-REPORT.
module tb_blake_nonce_scan;
  import blake_pkg::*;

  localparam int NW = 32;
  localparam int HW = 640;
  localparam int SW = 512;

  logic            clk = 1'b0;
  logic            rstb;
  logic            job_valid;
  logic            job_ready;
  logic [HW-NW-1:0] job_header;
  logic [NW-1:0]   job_nonce_start;
  logic [NW-1:0]   job_nonce_end;
  logic [SW-1:0]   job_target;
  logic            abort;
  logic            core_ena;
  logic [HW-1:0]   core_din;
  logic [SW-1:0]   core_dout;
  logic            core_rdy;
  logic            found_valid;
  logic            found_ready;
  logic [NW-1:0]   found_nonce;
  logic [SW-1:0]   found_hash;
  logic            done;
  logic            busy;
  logic [31:0]     hash_count;

  blake_nonce_scan dut (
    .clk             (clk),
    .rstb            (rstb),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_header      (job_header),
    .job_nonce_start (job_nonce_start),
    .job_nonce_end   (job_nonce_end),
    .job_target      (job_target),
    .abort           (abort),
    .core_ena        (core_ena),
    .core_din        (core_din),
    .core_dout       (core_dout),
    .core_rdy        (core_rdy),
    .found_valid     (found_valid),
    .found_ready     (found_ready),
    .found_nonce     (found_nonce),
    .found_hash      (found_hash),
    .done            (done),
    .busy            (busy),
    .hash_count      (hash_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Behavioural hash: mode 0 is a scrambled per-nonce value with the MSB forced
  // high (never <= 0); mode 1 returns specialHash for one nonce, all-ones otherwise.
  int             hashMode = 0;
  logic [NW-1:0]  specialNonce = '0;
  logic [SW-1:0]  specialHash = '0;

  function automatic logic [SW-1:0] hashOf(input logic [NW-1:0] n);
    logic [31:0]   m;
    logic [SW-1:0] h;
    if (hashMode == 1) return (n == specialNonce) ? specialHash : {SW{1'b1}};
    m = n * 32'h9E37_79B1 ^ 32'h5A5A_1234;
    m = m ^ (m >> 15);
    for (int k = 0; k < 16; k++) h[k*32 +: 32] = m ^ (32'h0101_0101 * k);
    h[SW-1] = 1'b1;
    return h;
  endfunction

  function automatic logic [SW-1:0] rand512();
    logic [SW-1:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural blake core driven from the negative edge.
  logic [NW-1:0]   issuedQ[$];
  int              enaCyc[$];
  int              rdyCyc[$];
  bit              corePending = 1'b0;
  int              coreCnt = 0;
  int              coreLatFixed = 3;
  logic [HW-1:0]   coreDinCap;
  logic [HW-NW-1:0] curHeader = '0;
  int              dinBad = 0;
  int              hdrBad = 0;

  always @(negedge clk) begin
    core_rdy  = 1'b0;
    core_dout = rand512();
    if (corePending) begin
      if (core_din !== coreDinCap) dinBad++;
      if (coreCnt <= 1) begin
        core_rdy    = 1'b1;
        core_dout   = hashOf(coreDinCap[NW-1:0]);
        corePending = 1'b0;
        rdyCyc.push_back(cyc);
      end else begin
        coreCnt--;
      end
    end
    if (core_ena) begin
      if (core_din[HW-1:NW] !== curHeader) hdrBad++;
      issuedQ.push_back(core_din[NW-1:0]);
      enaCyc.push_back(cyc);
      corePending = 1'b1;
      coreDinCap  = core_din;
      coreCnt     = (coreLatFixed > 0) ? coreLatFixed : $urandom_range(1, 5);
    end
  end

  // Host side of the hit interface plus event recording.
  typedef struct {
    logic [NW-1:0] nonce;
    logic [SW-1:0] hash;
  } hit_t;

  hit_t  hitsQ[$];
  int    hitCyc[$];
  int    foundRiseCyc[$];
  int    doneCnt = 0;
  int    doneCyc = -1;
  bit    readyRandom = 1'b0;
  logic  readyHold = 1'b1;
  logic  prevFv = 1'b0;

  always @(negedge clk) begin
    hit_t h;
    found_ready = readyRandom ? 1'($urandom_range(0, 1)) : readyHold;
    if (found_valid && !prevFv) foundRiseCyc.push_back(cyc);
    prevFv = found_valid;
    if (found_valid && found_ready) begin
      h.nonce = found_nonce;
      h.hash  = found_hash;
      hitsQ.push_back(h);
      hitCyc.push_back(cyc);
    end
    if (done) begin
      doneCnt++;
      doneCyc = cyc;
    end
  end

  int acceptCyc = -1;

  task automatic applyStimulus(input logic [NW-1:0] s, input logic [NW-1:0] e, input logic [SW-1:0] t);
    int guard = 0;
    issuedQ.delete(); enaCyc.delete(); rdyCyc.delete();
    hitsQ.delete(); hitCyc.delete(); foundRiseCyc.delete();
    doneCnt = 0;
    doneCyc = -1;
    while (!job_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!job_ready) checkOutput("job_ready timeout", 0, 1);
    curHeader       = rand512();
    job_header      = curHeader;
    job_nonce_start = s;
    job_nonce_end   = e;
    job_target      = t;
    job_valid       = 1'b1;
    acceptCyc       = cyc;
    @(negedge clk);
    job_valid       = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int guard = 0;
    while (doneCnt == 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (doneCnt == 0) checkOutput({name, " done timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic waitFound(input string name);
    int guard = 0;
    while (!found_valid && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!found_valid) checkOutput({name, " found timeout"}, 0, 1);
  endtask

  // Reference: enumerate the inclusive wrapping range, mark hash <= target.
  task automatic checkJob(input string name, input logic [NW-1:0] s, input logic [NW-1:0] e, input logic [SW-1:0] t);
    logic [NW-1:0] expN[$];
    hit_t          expH[$];
    hit_t          h;
    logic [NW-1:0] n;
    int            mism;
    n = s;
    while (expN.size() < 4096) begin
      expN.push_back(n);
      if (hashOf(n) <= t) begin
        h.nonce = n;
        h.hash  = hashOf(n);
        expH.push_back(h);
      end
      if (n == e) break;
      n = n + 1;
    end
    checkOutput({name, " hashes"}, issuedQ.size(), expN.size());
    mism = 0;
    for (int i = 0; i < issuedQ.size() && i < expN.size(); i++)
      if (issuedQ[i] !== expN[i]) mism++;
    checkOutput({name, " nonce order"}, mism, 0);
    checkOutput({name, " hits"}, hitsQ.size(), expH.size());
    mism = 0;
    for (int i = 0; i < hitsQ.size() && i < expH.size(); i++)
      if (hitsQ[i].nonce !== expH[i].nonce || hitsQ[i].hash !== expH[i].hash) mism++;
    checkOutput({name, " hit data"}, mism, 0);
    checkOutput({name, " done pulses"}, doneCnt, 1);
    checkOutput({name, " hash_count"}, hash_count, expN.size());
  endtask

  typedef struct {
    logic [NW-1:0] s;
    logic [NW-1:0] e;
    logic [SW-1:0] t;
    int            expHashes;
    int            expHits;
    bit            doneAfterHit;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [SW-1:0] tgt;
    logic [NW-1:0] s;
    logic [NW-1:0] e;
    int            stableBad;
    int            gapBad;
    int            staleRdy;

    rstb = 1'b0; job_valid = 1'b0; job_header = '0; job_nonce_start = '0;
    job_nonce_end = '0; job_target = '0; abort = 1'b0;

    vecs[0] = '{s: 32'd5,         e: 32'd5,    t: {SW{1'b1}}, expHashes: 1, expHits: 1, doneAfterHit: 1'b1};
    vecs[1] = '{s: 32'h10,        e: 32'h13,   t: '0,         expHashes: 4, expHits: 0, doneAfterHit: 1'b0};
    vecs[2] = '{s: 32'hFFFF_FFFE, e: 32'd1,    t: '0,         expHashes: 4, expHits: 0, doneAfterHit: 1'b0};
    vecs[3] = '{s: 32'h20,        e: 32'h27,   t: {SW{1'b1}}, expHashes: 8, expHits: 8, doneAfterHit: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset job_ready", job_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset core_ena", core_ena, 0);
    checkOutput("reset found_valid", found_valid, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset core_din zero", (core_din == '0), 1);
    checkOutput("reset found data zero", (found_nonce == '0 && found_hash == '0), 1);
    checkOutput("reset hash_count", hash_count, 0);
    rstb = 1'b1;
    @(negedge clk);

    // Directed table
    readyRandom  = 1'b1;
    coreLatFixed = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].s, vecs[i].e, vecs[i].t);
      waitDone($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d table hashes", i), issuedQ.size(), vecs[i].expHashes);
      checkOutput($sformatf("vec%0d table hits", i), hitsQ.size(), vecs[i].expHits);
      checkJob($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].t);
      if (vecs[i].doneAfterHit)
        checkOutput($sformatf("vec%0d done after hit", i), doneCyc,
                    (hitCyc.size() > 0) ? hitCyc[hitCyc.size()-1] + 1 : -1);
    end

    // Latency: accept->ena is 1 cycle, rdy->next ena and rdy->done are 2 cycles
    readyRandom  = 1'b0;
    readyHold    = 1'b1;
    coreLatFixed = 3;
    applyStimulus(32'h100, 32'h103, '0);
    waitDone("lat");
    checkOutput("lat first ena", (enaCyc.size() > 0) ? enaCyc[0] : -1, acceptCyc + 1);
    gapBad = 0;
    for (int k = 0; k + 1 < enaCyc.size() && k < rdyCyc.size(); k++)
      if (enaCyc[k+1] != rdyCyc[k] + 2) gapBad++;
    checkOutput("lat rdy to next ena", gapBad, 0);
    checkOutput("lat rdy to done", doneCyc, (rdyCyc.size() > 0) ? rdyCyc[rdyCyc.size()-1] + 2 : -1);
    checkJob("lat", 32'h100, 32'h103, '0);

    // Hit back-pressure: hash equals target exactly for nonce 3 only
    hashMode     = 1;
    specialNonce = 32'd3;
    tgt          = rand512();
    tgt[SW-1]    = 1'b0;
    specialHash  = tgt;
    readyHold    = 1'b0;
    applyStimulus(32'd0, 32'd5, tgt);
    waitFound("bp");
    stableBad = 0;
    repeat (10) begin
      if (!found_valid || found_nonce !== 32'd3 || found_hash !== tgt || core_ena) stableBad++;
      @(negedge clk);
    end
    checkOutput("bp hit held stable", stableBad, 0);
    readyHold = 1'b1;
    waitDone("bp");
    checkOutput("bp found latency", (foundRiseCyc.size() > 0) ? foundRiseCyc[0] : -1,
                (rdyCyc.size() > 3) ? rdyCyc[3] + 2 : -2);
    checkOutput("bp resume after accept", (enaCyc.size() > 4) ? enaCyc[4] : -1,
                (hitCyc.size() > 0) ? hitCyc[0] + 1 : -2);
    checkJob("bp", 32'd0, 32'd5, tgt);
    hashMode = 0;

    // Abort in WAIT, then a new job while the old hash is still in flight
    coreLatFixed = 8;
    applyStimulus(32'h40, 32'h60, '0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort drain blocks job_ready", job_ready, 0);
    coreLatFixed = 2;
    applyStimulus(32'd7, 32'd7, {SW{1'b1}});
    waitDone("abort");
    staleRdy = (rdyCyc.size() > 0) ? rdyCyc[0] : -10;
    checkOutput("abort new ena after stale rdy", (enaCyc.size() > 0) ? enaCyc[0] : -1, staleRdy + 2);
    checkJob("abort", 32'd7, 32'd7, {SW{1'b1}});

    // Reset asserted for one cycle while in REPORT
    readyHold = 1'b0;
    applyStimulus(32'd9, 32'd9, {SW{1'b1}});
    waitFound("rst");
    rstb = 1'b0;
    @(negedge clk);
    checkOutput("rst found_valid", found_valid, 0);
    checkOutput("rst job_ready", job_ready, 1);
    checkOutput("rst hash_count", hash_count, 0);
    checkOutput("rst busy", busy, 0);
    rstb = 1'b1;
    readyHold = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst no done", doneCnt, 0);
    checkOutput("rst no hit taken", hitsQ.size(), 0);

    // Randomized jobs against the model
    readyRandom  = 1'b1;
    coreLatFixed = 0;
    for (int j = 0; j < 8; j++) begin
      s = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 5) : $urandom;
      e = s + $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 0) begin
        tgt = rand512();
        tgt[SW-1] = 1'b1;
      end else begin
        tgt = hashOf(s + $urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) tgt[31:0] = tgt[31:0] - 1;
      end
      applyStimulus(s, e, tgt);
      waitDone($sformatf("rand%0d", j));
      checkJob($sformatf("rand%0d", j), s, e, tgt);
    end

    checkOutput("core_din stable while hashing", dinBad, 0);
    checkOutput("core_din header", hdrBad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
